// File: rtl/ins_fetch_ctrl_if.sv
// Queue-side request/answer and RAM-port signals of the instruction fetch engine.
// master = fetch engine view, slave = queue/arbiter/RAM view.
interface ins_fetch_ctrl_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17
);
    logic                      req_valid;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic                      ins_ok;
    logic [31:0]               ins_ans;
    logic                      busy;
    logic                      mem_req;
    logic                      mem_grant;
    logic [RAM_ADDR_WIDTH-1:0] mem_a;
    logic                      mem_wr;
    logic [7:0]                mem_din;

    modport master (
        input  req_valid, req_addr, mem_grant, mem_din,
        output ins_ok, ins_ans, busy, mem_req, mem_a, mem_wr
    );

    modport slave (
        output req_valid, req_addr, mem_grant, mem_din,
        input  ins_ok, ins_ans, busy, mem_req, mem_a, mem_wr
    );
endinterface

// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch engine: reads 4 bytes over the byte-wide RAM port and returns them as one
// little-endian word. Define INS_FETCH_PREFETCH_EN to add a one-entry next-line prefetch buffer.
module ins_fetch_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear_flag,
    ins_fetch_ctrl_if.master bus
);
    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [2:0]            issue_cnt;
    logic [1:0]            recv_cnt;
    logic                  pending;
    logic [23:0]           shift;
    logic                  ok_r;
    logic                  busy_r;
    logic [31:0]           ans_r;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  issue;
    logic                  capture;
    logic                  last_byte;
    logic [31:0]           word;
    logic                  unused_hi;

    assign issue_addr  = base + ADDR_WIDTH'(issue_cnt);
    assign unused_hi   = ^issue_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];
    assign bus.mem_a   = issue_addr[RAM_ADDR_WIDTH-1:0];
    // A flush cycle never issues, so nothing is left in flight behind it.
    assign bus.mem_req = (state == FETCH) && !issue_cnt[2] && rdy && !clear_flag;
    assign bus.mem_wr  = 1'b0;
    assign issue       = bus.mem_req && bus.mem_grant;
    assign capture     = pending && rdy;
    assign last_byte   = capture && (recv_cnt == 2'd3);
    assign word        = {bus.mem_din, shift};
    assign bus.ins_ok  = ok_r && rdy;
    assign bus.ins_ans = ans_r;
    assign bus.busy    = busy_r;

`ifdef INS_FETCH_PREFETCH_EN
    logic                  pf_active;
    logic                  pf_valid;
    logic                  want_pf;
    logic [ADDR_WIDTH-1:0] pf_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [31:0]           pf_data;
    logic                  pf_hit;
    logic                  pf_match;
    logic                  pf_abort;

    assign pf_hit   = pf_valid && (bus.req_addr == pf_addr);
    assign pf_match = pf_active && bus.req_valid && (bus.req_addr == base);
    assign pf_abort = pf_active && bus.req_valid && (bus.req_addr != base);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pending   <= 1'b0;
            shift     <= '0;
            ok_r      <= 1'b0;
            busy_r    <= 1'b0;
            ans_r     <= '0;
`ifdef INS_FETCH_PREFETCH_EN
            pf_active <= 1'b0;
            pf_valid  <= 1'b0;
            want_pf   <= 1'b0;
            pf_addr   <= '0;
            last_addr <= '0;
            pf_data   <= '0;
`endif
        end else if (clear_flag) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pending   <= 1'b0;
            ok_r      <= 1'b0;
            busy_r    <= 1'b0;
`ifdef INS_FETCH_PREFETCH_EN
            pf_active <= 1'b0;
            pf_valid  <= 1'b0;
            want_pf   <= 1'b0;
`endif
        end else if (rdy) begin
            ok_r    <= 1'b0;
            pending <= issue;
            if (issue)
                issue_cnt <= issue_cnt + 3'd1;
            if (capture) begin
                recv_cnt <= recv_cnt + 2'd1;
                case (recv_cnt)
                    2'd0:    shift[7:0]   <= bus.mem_din;
                    2'd1:    shift[15:8]  <= bus.mem_din;
                    2'd2:    shift[23:16] <= bus.mem_din;
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
`ifdef INS_FETCH_PREFETCH_EN
                    if (bus.req_valid && pf_hit) begin
                        ok_r      <= 1'b1;
                        ans_r     <= pf_data;
                        pf_valid  <= 1'b0;
                        last_addr <= bus.req_addr;
                        want_pf   <= 1'b1;
                    end else if (bus.req_valid) begin
                        base      <= bus.req_addr;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        busy_r    <= 1'b1;
                        want_pf   <= 1'b0;
                        state     <= FETCH;
                    end else if (want_pf) begin
                        // background fetch: busy stays low so the queue may interrupt it
                        base      <= last_addr + ADDR_WIDTH'(4);
                        pf_addr   <= last_addr + ADDR_WIDTH'(4);
                        pf_valid  <= 1'b0;
                        pf_active <= 1'b1;
                        want_pf   <= 1'b0;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= FETCH;
                    end
`else
                    if (bus.req_valid) begin
                        base      <= bus.req_addr;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        busy_r    <= 1'b1;
                        state     <= FETCH;
                    end
`endif
                end
                FETCH: begin
`ifdef INS_FETCH_PREFETCH_EN
                    if (pf_abort) begin
                        // restart on the demand address; the in-flight prefetch byte is dropped
                        base      <= bus.req_addr;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        pending   <= 1'b0;
                        pf_active <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        if (pf_match) begin
                            pf_active <= 1'b0;
                            busy_r    <= 1'b1;
                        end
                        if (last_byte) begin
                            state     <= IDLE;
                            busy_r    <= 1'b0;
                            pf_active <= 1'b0;
                            if (pf_active && !pf_match) begin
                                pf_data  <= word;
                                pf_valid <= 1'b1;
                            end else begin
                                ok_r      <= 1'b1;
                                ans_r     <= word;
                                last_addr <= base;
                                want_pf   <= 1'b1;
                            end
                        end
                    end
`else
                    if (last_byte) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        ok_r   <= 1'b1;
                        ans_r  <= word;
                    end
`endif
                end
            endcase
        end
    end
endmodule
